mmc_cmd_init_sequencer: RTL and testbench

Sequences the card-initialisation command layers (CMD0, CMD8, CMD55/ACMD41 loop wrapper, CMD16) over the single shared byte-level MMC SPI interface.
- Issues the power-up dummy clocks first.
- Starts each command layer in turn through its start/end handshake and muxes that layer's REQ/CS/DATA onto the shared interface.
- Inserts one idle byte between commands.
- Enforces a per-command timeout with bounded retry.
- Sits between the top-level MMC controller and the four command-layer sub-blocks.

---
 rtl/mmc_cmd_init_sequencer.sv | 120 ++++++++++++
 tb/tb_mmc_cmd_init_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mmc_cmd_init_sequencer.sv
// mmc_cmd_init_sequencer: runs the SPI card-init command layers in order over one shared byte interface
//   iCLOCK, iRESET_SYNC      : clock, synchronous active-high reset
//   iINIT_START              : kicks off the sequence from IDLE
//   oINIT_BUSY/END/ERROR     : sequencer busy, completion pulse, retry-exhausted pulse
//   oSUB_START, iSUB_END     : one-hot start pulse / end pulse per command layer
//   oSUB_ABORT               : reset to the command layers (external reset or timeout abort)
//   iSUB_REQ/CS/DATA         : per-layer byte interface, muxed by the current slot
//   oMMC_REQ/CS/DATA, iMMC_BUSY : shared byte engine interface
module mmc_cmd_init_sequencer #(
    parameter int DUMMY_BYTES = 10,
    parameter int TIMEOUT     = 50000,
    parameter int MAX_RETRY   = 3
) (
    input  logic        iCLOCK,
    input  logic        iRESET_SYNC,
    input  logic        iINIT_START,
    output logic        oINIT_BUSY,
    output logic        oINIT_END,
    output logic        oINIT_ERROR,
    output logic [3:0]  oSUB_START,
    input  logic [3:0]  iSUB_END,
    output logic        oSUB_ABORT,
    input  logic [3:0]  iSUB_REQ,
    input  logic [3:0]  iSUB_CS,
    input  logic [31:0] iSUB_DATA,
    output logic        oMMC_REQ,
    input  logic        iMMC_BUSY,
    output logic        oMMC_CS,
    output logic [7:0]  oMMC_DATA
);
    typedef enum logic [2:0] {S_IDLE, S_DUMMY, S_START, S_WAIT, S_GAP, S_DONE, S_ERROR} state_t;
    localparam int CW = $clog2(DUMMY_BYTES + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);
    state_t        r_state;
    logic [1:0]    r_slot;
    logic [CW-1:0] r_count;
    logic [15:0]   r_timer;
    logic [RW-1:0] r_retry;
    logic [3:0]    r_sub_start;
    logic          r_init_end;
    logic          r_init_error;
    logic          w_wait;
    logic          w_fill;
    logic          w_end;
    logic          w_timeout;
    // DUMMY and GAP push 0xFF filler bytes whenever the engine is free
    assign w_wait     = r_state == S_WAIT;
    assign w_fill     = (r_state == S_DUMMY || r_state == S_GAP) && !iMMC_BUSY;
    assign w_end      = w_wait && iSUB_END[r_slot];
    // an END arriving in the timeout cycle takes priority over the abort
    assign w_timeout  = w_wait && !iSUB_END[r_slot] && r_timer == 16'(TIMEOUT - 1);
    assign oSUB_ABORT = iRESET_SYNC || w_timeout;
    assign oMMC_REQ   = w_wait ? iSUB_REQ[r_slot] : w_fill;
    assign oMMC_CS    = w_wait ? iSUB_CS[r_slot] : 1'b1;
    assign oMMC_DATA  = w_wait ? iSUB_DATA[{r_slot, 3'b000} +: 8] : 8'hFF;
    assign oINIT_BUSY = r_state != S_IDLE;
    assign oSUB_START  = r_sub_start;
    assign oINIT_END   = r_init_end;
    assign oINIT_ERROR = r_init_error;
    always_ff @(posedge iCLOCK) begin
        r_sub_start  <= 4'b0;
        r_init_end   <= 1'b0;
        r_init_error <= 1'b0;
        if (iRESET_SYNC) begin
            r_state <= S_IDLE;
            r_slot  <= 2'd0;
            r_count <= '0;
            r_timer <= 16'd0;
            r_retry <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (iINIT_START) begin
                    r_state <= S_DUMMY;
                    r_count <= '0;
                    r_slot  <= 2'd0;
                    r_retry <= '0;
                end
                S_DUMMY: if (w_fill) begin
                    r_count <= r_count + 1'b1;
                    if (r_count == CW'(DUMMY_BYTES - 1)) begin
                        r_state     <= S_START;
                        r_sub_start <= 4'b1 << r_slot;
                    end
                end
                S_START: begin
                    r_timer <= 16'd0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_timer <= r_timer + 16'd1;
                    if (w_end) begin
                        if (r_slot == 2'd3) begin
                            r_state    <= S_DONE;
                            r_init_end <= 1'b1;
                        end else begin
                            r_slot  <= r_slot + 2'd1;
                            r_retry <= '0;
                            r_state <= S_GAP;
                        end
                    end else if (w_timeout) begin
                        if (r_retry == RW'(MAX_RETRY)) begin
                            r_state      <= S_ERROR;
                            r_init_error <= 1'b1;
                        end else begin
                            r_retry <= r_retry + 1'b1;
                            r_state <= S_GAP;
                        end
                    end
                end
                S_GAP: if (w_fill) begin
                    r_state     <= S_START;
                    r_sub_start <= 4'b1 << r_slot;
                end
                S_DONE:  r_state <= S_IDLE;
                S_ERROR: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mmc_cmd_init_sequencer.sv
// tb_mmc_cmd_init_sequencer: directed timeline bench for the card-init sequencer
module tb_mmc_cmd_init_sequencer;
    localparam int DB = 10;
    localparam int TO = 100;
    localparam int MR = 3;
    localparam int N  = 1120;
    logic        clk = 1'b0;
    logic        rst, start, busy;
    logic [3:0]  sub_end, sub_req, sub_cs;
    logic [31:0] sub_data;
    logic        o_busy, o_end, o_err, o_abort, o_req, o_cs;
    logic [3:0]  o_start;
    logic [7:0]  o_data;
    logic        st_rst[N], st_start[N], st_busy[N];
    logic [3:0]  st_end[N];
    logic        e_busy[N], e_end[N], e_err[N], e_abort[N], e_req[N];
    logic [3:0]  e_start[N];
    int          e_kind[N], e_slot[N];
    int          cyc = 0, n_vec = 0, n_err = 0;
    logic        xr, xc;
    logic [7:0]  xd;
    mmc_cmd_init_sequencer #(.DUMMY_BYTES(DB), .TIMEOUT(TO), .MAX_RETRY(MR)) dut (
        .iCLOCK(clk), .iRESET_SYNC(rst), .iINIT_START(start),
        .oINIT_BUSY(o_busy), .oINIT_END(o_end), .oINIT_ERROR(o_err),
        .oSUB_START(o_start), .iSUB_END(sub_end), .oSUB_ABORT(o_abort),
        .iSUB_REQ(sub_req), .iSUB_CS(sub_cs), .iSUB_DATA(sub_data),
        .oMMC_REQ(o_req), .iMMC_BUSY(busy), .oMMC_CS(o_cs), .oMMC_DATA(o_data)
    );
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask
    // kind 0: idle bus, 1: filler byte offered, 2: bus owned by layer slot
    task automatic put(input int t, input int kind, input int slot);
        e_kind[t] = kind;
        e_slot[t] = slot;
        e_busy[t] = 1'b1;
        e_req[t]  = 1'b0;
    endtask
    // builds the expected timeline of one init run; d[k] = cycles from START to the layer's END, 0 = never
    task automatic seq(input int c0, input int d0, input int d1, input int d2, input int d3, output int te);
        int d[4];
        int t, acc, s, lim, tries;
        bit ab, fin;
        d = '{d0, d1, d2, d3};
        st_start[c0] = 1'b1;
        st_start[c0 + 3] = 1'b1;
        t = c0 + 1;
        acc = 0;
        while (acc < DB) begin
            put(t, 1, 0);
            e_req[t] = !st_busy[t];
            if (!st_busy[t]) acc++;
            t++;
        end
        fin = 0;
        for (int k = 0; k < 4 && !fin; k++) begin
            tries = 0;
            ab = 1;
            while (ab && !fin) begin
                put(t, 0, 0);
                e_start[t][k] = 1'b1;
                s = t;
                t++;
                ab = !(d[k] > 0 && d[k] <= TO);
                lim = ab ? TO : d[k];
                st_end[s + 5][(k + 1) % 4] = 1'b1;
                for (int j = 1; j <= lim; j++) begin
                    put(t, 2, k);
                    t++;
                end
                if (ab) e_abort[t - 1] = 1'b1;
                else st_end[t - 1][k] = 1'b1;
                if (!ab && k == 3) begin
                    put(t, 0, 0);
                    e_end[t] = 1'b1;
                    t++;
                    fin = 1;
                end else if (ab && tries == MR) begin
                    put(t, 0, 0);
                    e_err[t] = 1'b1;
                    t++;
                    fin = 1;
                end else begin
                    if (ab) tries++;
                    while (st_busy[t]) begin
                        put(t, 1, 0);
                        t++;
                    end
                    put(t, 1, 0);
                    e_req[t] = 1'b1;
                    t++;
                end
            end
        end
        te = t;
    endtask
    always @(negedge clk) if (cyc >= 1) begin
        xr = e_kind[cyc] == 2 ? sub_req[e_slot[cyc]] : e_kind[cyc] == 1 ? e_req[cyc] : 1'b0;
        xc = e_kind[cyc] == 2 ? sub_cs[e_slot[cyc]] : 1'b1;
        xd = e_kind[cyc] == 2 ? sub_data[8 * e_slot[cyc] +: 8] : 8'hFF;
        chk("busy", o_busy, e_busy[cyc]);
        chk("init_end", o_end, e_end[cyc]);
        chk("init_error", o_err, e_err[cyc]);
        chk("sub_start", o_start, e_start[cyc]);
        chk("sub_abort", o_abort, e_abort[cyc]);
        chk("mmc_req", o_req, xr);
        chk("mmc_cs", o_cs, xc);
        chk("mmc_data", o_data, xd);
        case (cyc)
            37:   chk("pin_gap_req", o_req, 1);
            82:   chk("pin_start_slot3", o_start, 8'h08);
            103:  chk("pin_done", o_end, 1);
            104:  chk("pin_busy_fall", o_busy, 0);
            140:  chk("pin_busy_dummy_start", o_start, 8'h01);
            371:  chk("pin_race_no_abort", o_abort, 0);
            373:  chk("pin_race_advance", o_start, 8'h02);
            400: begin
                chk("pin_mux_data", o_data, 8'h50);
                chk("pin_mux_cs", o_cs, 0);
                chk("pin_mux_req", o_req, 1);
            end
            593, 695, 797, 899: chk("pin_abort", o_abort, 1);
            900:  chk("pin_error", o_err, 1);
            984:  chk("pin_reset_abort", o_abort, 1);
            985:  chk("pin_reset_idle", o_busy, 0);
            1001: chk("pin_restart_req", o_req, 1);
            1011: chk("pin_restart_slot0", o_start, 8'h01);
            default: ;
        endcase
    end
    initial begin
        int te;
        for (int i = 0; i < N; i++) begin
            st_rst[i] = 0; st_start[i] = 0; st_busy[i] = 0; st_end[i] = 4'b0;
            e_busy[i] = 0; e_end[i] = 0; e_err[i] = 0; e_abort[i] = 0; e_req[i] = 0;
            e_start[i] = 4'b0; e_kind[i] = 0; e_slot[i] = 0;
        end
        st_rst[0] = 1; st_rst[1] = 1; st_start[1] = 1;
        e_abort[0] = 1; e_abort[1] = 1;
        seq(5, 20, 20, 20, 20, te);
        for (int t = 121; t < 140; t++) st_busy[t] = (t % 2 == 0);
        st_busy[161] = 1;
        seq(120, 20, 20, 20, 20, te);
        seq(260, 100, 20, 20, 20, te);
        seq(460, 20, 0, 20, 20, te);
        seq(920, 20, 20, 20, 20, te);
        st_rst[983] = 1; st_rst[984] = 1; st_start[984] = 1;
        e_abort[983] = 1;
        for (int i = 984; i < te; i++) begin
            e_kind[i] = 0; e_busy[i] = 0; e_start[i] = 0; e_end[i] = 0;
            e_err[i] = 0; e_abort[i] = 0; e_req[i] = 0; st_end[i] = 4'b0;
        end
        e_abort[984] = 1;
        seq(1000, 20, 20, 20, 20, te);
        sub_req  = 4'b0101;
        sub_cs   = 4'b1010;
        sub_data = 32'hC35A960F;
        for (int i = 0; i < N; i++) begin
            if (i == 250) begin
                sub_req  = 4'b1111;
                sub_cs   = 4'b1011;
                sub_data = 32'hAA50AAAA;
            end
            rst     = st_rst[i];
            start   = st_start[i];
            busy    = st_busy[i];
            sub_end = st_end[i];
            cyc     = i;
            @(posedge clk);
            #1;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
